// File: rtl/axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo
//   Synchronous AXI4-Stream FIFO with first-word-fall-through output, fill
//   level, almost-full/almost-empty flags and an optional store-and-forward
//   packet mode.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready   upstream (write) stream
//   m_tdata/m_tvalid/m_tlast/m_tready   downstream (read) stream
//   full, empty, almost_full, almost_empty   status flags from the fill level
//   level             stored entries, 0..DEPTH
//   pkt_count         number of tlast beats currently stored
// ---------------------------------------------------------------------------
module axis_pkt_fifo #(
    parameter int DW          = 16,
    parameter int AW          = 4,
    parameter int PACKET_MODE = 0,
    parameter int AFULL_TH    = 2**AW - 2,
    parameter int AEMPTY_TH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   level,
    output logic [AW:0]   pkt_count
);

    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] DEPTH_L  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AFULL_L  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_L = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [DW:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic [DW:0]   rd_word;
    logic          wr_fire, rd_fire, rd_ok;

    assign wr_fire = s_tvalid && s_tready;
    assign rd_fire = m_tvalid && m_tready;

    // Extra pointer MSB tells a full FIFO (MSBs differ) from an empty one,
    // so the pointer difference is the exact fill level 0..DEPTH.
    assign level        = wr_ptr - rd_ptr;
    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AFULL_L);
    assign almost_empty = (level <= AEMPTY_L);

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_fire) wr_ptr_nxt = wr_ptr + ONE;
        if (rd_fire) rd_ptr_nxt = rd_ptr + ONE;
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    // In packet mode output is held until a whole packet is stored; a full
    // FIFO releases anyway so a packet larger than DEPTH cannot deadlock.
    always_comb begin
        rd_ok = !empty;
        if (PACKET_MODE != 0) rd_ok = !empty && ((pkt_count != '0) || full);
    end

    // Fall-through read straight from the head entry; gated to zero while
    // nothing is presented so outputs are clean during and after reset.
    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign m_tvalid = rd_ok;
    assign m_tdata  = rd_ok ? rd_word[DW-1:0] : '0;
    assign m_tlast  = rd_ok && rd_word[DW];

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
    end

    // s_tready is registered from the next level so it equals !full from the
    // first edge after reset release without any path from s_tvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_count <= '0;
            s_tready  <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            s_tready <= (level_nxt != DEPTH_L);
            if ((wr_fire && s_tlast) && !(rd_fire && m_tlast))
                pkt_count <= pkt_count + ONE;
            else if (!(wr_fire && s_tlast) && (rd_fire && m_tlast))
                pkt_count <= pkt_count - ONE;
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
module tb_axis_pkt_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;          // 0: cut-through instance, 1: packet-mode instance
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b0;

    logic        o0_s_tready, o0_m_tvalid, o0_m_tlast, o0_full, o0_empty, o0_af, o0_ae;
    logic        o1_s_tready, o1_m_tvalid, o1_m_tlast, o1_full, o1_empty, o1_af, o1_ae;
    logic [15:0] o0_m_tdata, o1_m_tdata;
    logic [4:0]  o0_level, o1_level, o0_pkt, o1_pkt;

    logic        s_tready, m_tvalid, m_tlast, full, empty, af, ae;
    logic [15:0] m_tdata;
    logic [4:0]  level, pkt_count;

    int compared = 0;
    int mismatched = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    axis_pkt_fifo #(.DW(16), .AW(4), .PACKET_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid && !sel), .s_tlast(s_tlast), .s_tready(o0_s_tready),
        .m_tdata(o0_m_tdata), .m_tvalid(o0_m_tvalid), .m_tlast(o0_m_tlast), .m_tready(m_tready && !sel),
        .full(o0_full), .empty(o0_empty), .almost_full(o0_af), .almost_empty(o0_ae),
        .level(o0_level), .pkt_count(o0_pkt)
    );

    axis_pkt_fifo #(.DW(16), .AW(4), .PACKET_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel), .s_tlast(s_tlast), .s_tready(o1_s_tready),
        .m_tdata(o1_m_tdata), .m_tvalid(o1_m_tvalid), .m_tlast(o1_m_tlast), .m_tready(m_tready && sel),
        .full(o1_full), .empty(o1_empty), .almost_full(o1_af), .almost_empty(o1_ae),
        .level(o1_level), .pkt_count(o1_pkt)
    );

    assign s_tready  = sel ? o1_s_tready : o0_s_tready;
    assign m_tvalid  = sel ? o1_m_tvalid : o0_m_tvalid;
    assign m_tlast   = sel ? o1_m_tlast  : o0_m_tlast;
    assign m_tdata   = sel ? o1_m_tdata  : o0_m_tdata;
    assign full      = sel ? o1_full     : o0_full;
    assign empty     = sel ? o1_empty    : o0_empty;
    assign af        = sel ? o1_af       : o0_af;
    assign ae        = sel ? o1_ae       : o0_ae;
    assign level     = sel ? o1_level    : o0_level;
    assign pkt_count = sel ? o1_pkt      : o0_pkt;

    // Monitor: every beat the DUT hands over is checked against the queue.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL out_beat: got tlast=%0b data=%04h, required none (queue empty)", m_tlast, m_tdata);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({m_tlast, m_tdata} !== e) begin
                    mismatched++;
                    $display("FAIL out_beat: got tlast=%0b data=%04h, required tlast=%0b data=%04h",
                             m_tlast, m_tdata, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive one beat and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic write_beat(input logic [15:0] d, input logic l);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        n = 0;
        while (!s_tready && n < 100) begin
            tick();
            n++;
        end
        if (!s_tready) begin
            chk("write_timeout", 32'(s_tready), 32'd1);
        end else begin
            exp_q.push_back({l, d});
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic read_one();
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        exp_q.delete();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_almost_full", 32'(af), 0);
        chk("rst_almost_empty", 32'(ae), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        rst = 1'b0;
        chk("s_tready_before_edge", 32'(s_tready), 0);
        tick();
        chk("s_tready_after_edge", 32'(s_tready), 1);

        // Cut-through: three beats, fall-through latency
        m_tready = 1'b1;
        write_beat(16'h0001, 1'b0);
        chk("fwft_m_tvalid", 32'(m_tvalid), 1);
        chk("fwft_m_tdata", 32'(m_tdata), 32'h0001);
        write_beat(16'h0002, 1'b0);
        write_beat(16'h0003, 1'b1);
        repeat (2) tick();
        chk("t1_empty", 32'(empty), 1);
        chk("t1_level", 32'(level), 0);

        // Fill to full, 17th beat refused, one read frees a slot
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) write_beat(16'h0100 + 16'(i), 1'b0);
        chk("full_flag", 32'(full), 1);
        chk("full_level", 32'(level), 16);
        chk("full_s_tready", 32'(s_tready), 0);
        chk("full_almost_full", 32'(af), 1);
        s_tvalid = 1'b1;
        s_tdata  = 16'hDEAD;
        tick();
        s_tvalid = 1'b0;
        chk("beat17_level", 32'(level), 16);
        read_one();
        chk("after_read_level", 32'(level), 15);
        chk("after_read_s_tready", 32'(s_tready), 1);
        chk("after_read_full", 32'(full), 0);
        m_tready = 1'b1;
        repeat (12) tick();
        chk("drain_level3", 32'(level), 3);
        chk("drain_ae_at3", 32'(ae), 0);
        tick();
        chk("drain_ae_at2", 32'(ae), 1);
        repeat (2) tick();
        chk("drain_empty", 32'(empty), 1);

        // Streaming 40 beats through the wrap point
        for (int i = 0; i < 40; i++) begin
            write_beat(16'h2000 + 16'(i), (i % 8) == 7);
            if (i == 20) chk("stream_level", 32'(level), 1);
        end
        repeat (2) tick();
        chk("stream_empty", 32'(empty), 1);
        chk("stream_all_out", 32'(exp_q.size()), 0);

        // Packet mode: held until tlast
        m_tready = 1'b0;
        sel = 1'b1;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) write_beat(16'h0031 + 16'(i), 1'b0);
        chk("pkt_hold_m_tvalid", 32'(m_tvalid), 0);
        chk("pkt_hold_level", 32'(level), 4);
        write_beat(16'h0035, 1'b1);
        chk("pkt_release_m_tvalid", 32'(m_tvalid), 1);
        chk("pkt_release_count", 32'(pkt_count), 1);
        repeat (6) tick();
        chk("pkt_drain_count", 32'(pkt_count), 0);
        chk("pkt_drain_empty", 32'(empty), 1);

        // Packet mode: oversize packet released by full override
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) write_beat(16'h0040 + 16'(i), 1'b0);
        chk("ovr_full", 32'(full), 1);
        chk("ovr_m_tvalid", 32'(m_tvalid), 1);
        chk("ovr_pkt_count", 32'(pkt_count), 0);
        read_one();
        chk("ovr_hold_again", 32'(m_tvalid), 0);
        write_beat(16'h0050, 1'b1);
        chk("ovr_tail_count", 32'(pkt_count), 1);
        chk("ovr_tail_m_tvalid", 32'(m_tvalid), 1);
        m_tready = 1'b1;
        repeat (17) tick();
        chk("ovr_drain_empty", 32'(empty), 1);
        chk("ovr_drain_count", 32'(pkt_count), 0);

        // Asynchronous reset mid-packet
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) write_beat(16'h0060 + 16'(i), 1'b0);
        chk("mid_level", 32'(level), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_level", 32'(level), 0);
        chk("async_m_tvalid", 32'(m_tvalid), 0);
        chk("async_m_tdata", 32'(m_tdata), 0);
        chk("async_s_tready", 32'(s_tready), 0);
        chk("async_empty", 32'(empty), 1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) write_beat(16'h0070 + 16'(i), i == 2);
        chk("post_rst_count", 32'(pkt_count), 1);
        chk("post_rst_level", 32'(level), 3);
        m_tready = 1'b1;
        repeat (5) tick();
        chk("post_rst_empty", 32'(empty), 1);
        chk("final_all_out", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
